// File: rtl/fxp_div_seq_if.sv
// fxp_div_seq_if
// Operand/result handshake bundle for the sequential fixed-point divider.
//   in_valid/in_ready : operand pair handshake (ina dividend, inb divisor)
//   out_valid/out_ready : result handshake (out quotient, overflow flag)
//   div_by_zero : present only when FXP_DIV_DBZ_EN is defined
// Modports: master = operand producer / result consumer, slave = divider.
// Optional macro: FXP_DIV_DBZ_EN.
interface fxp_div_seq_if #(
  parameter int WA = 16,
  parameter int WB = 16,
  parameter int WO = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [WA-1:0] ina;
  logic [WB-1:0] inb;
  logic          out_valid;
  logic          out_ready;
  logic [WO-1:0] out;
  logic          overflow;
`ifdef FXP_DIV_DBZ_EN
  logic          div_by_zero;

  modport master (
    output in_valid, ina, inb, out_ready,
    input  in_ready, out_valid, out, overflow, div_by_zero
  );
  modport slave (
    input  in_valid, ina, inb, out_ready,
    output in_ready, out_valid, out, overflow, div_by_zero
  );
`else
  modport master (
    output in_valid, ina, inb, out_ready,
    input  in_ready, out_valid, out, overflow
  );
  modport slave (
    input  in_valid, ina, inb, out_ready,
    output in_ready, out_valid, out, overflow
  );
`endif
endinterface

// File: rtl/fxp_div_seq.sv
// fxp_div_seq
// Sequential signed fixed-point divider, out = ina / inb, restoring radix-2,
// one quotient bit per cycle. Magnitude is rounded half-up via a guard bit
// (ROUND=1) or truncated (ROUND=0); results outside the output Q-format
// saturate with overflow=1. Divide by zero returns max/min by dividend sign.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : fxp_div_seq_if.slave (in_valid/in_ready/ina/inb,
//           out_valid/out_ready/out/overflow[/div_by_zero])
// Optional macro: FXP_DIV_DBZ_EN adds div_by_zero, high with out_valid when
// the held result came from a zero divisor.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand pair
// DIV   | shifting one dividend bit per cycle into the remainder
// FIN   | round, saturate and sign-correct the raw quotient, register result
// DONE  | out_valid=1, result held until out_ready
module fxp_div_seq #(
  parameter int WIIA  = 8,
  parameter int WIFA  = 8,
  parameter int WIIB  = 8,
  parameter int WIFB  = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter bit ROUND = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  fxp_div_seq_if.slave bus
);

  localparam int WA   = WIIA + WIFA;
  localparam int WB   = WIIB + WIFB;
  localparam int WO   = WOI + WOF;
  localparam int S    = WIFB + WOF + 1 - WIFA;
  localparam int WN   = WA + S;
  localparam int CW   = ((WN > WO) ? WN : WO) + 1;
  localparam int CNTW = (WN > 1) ? $clog2(WN) : 1;

  localparam logic [CW-1:0] LIM_NEG = CW'(1) << (WO - 1);
  localparam logic [CW-1:0] LIM_POS = LIM_NEG - CW'(1);
  localparam logic [WO-1:0] OUT_MAX = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] OUT_MIN = {1'b1, {(WO-1){1'b0}}};

  if (WIFB + WOF + 1 < WIFA) begin : g_bad_qfmt
    $fatal(1, "fxp_div_seq: WIFB+WOF+1 must be >= WIFA");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic            in_ready;
  logic            out_valid;
  logic            accept;

  logic [WN-1:0]   n_q;
  logic [WB:0]     b_q;
  logic [WB:0]     rem_q;
  logic [WN-1:0]   r_q;
  logic [CNTW-1:0] cnt_q;
  logic            sign_q;
  logic            a_neg_q;
  logic            dbz_q;
  logic [WO-1:0]   out_q;
  logic            ovf_q;

  // Operand magnitudes are one bit wider so the most negative value is exact.
  logic [WA:0]     a_ext, mag_a;
  logic [WB:0]     b_ext, mag_b;
  logic            inb_zero;

  logic [WB+1:0]   trial;
  logic            ge;
  logic [WB:0]     diff;

  logic [WN-1:0]   m;
  logic [CW-1:0]   m_ext;
  logic [WO-1:0]   mag_o, neg_o;
  logic            sat_pos, sat_neg;
  logic [WO-1:0]   res_out;
  logic            res_ovf;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = inb_zero ? FIN : DIV;
      end
      DIV: begin
        if (cnt_q == '0) state_d = FIN;
      end
      FIN: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = (state_q == IDLE) && bus.in_valid;

  // ---------------------------------------------------------- operands
  always_comb begin
    a_ext    = {bus.ina[WA-1], bus.ina};
    b_ext    = {bus.inb[WB-1], bus.inb};
    mag_a    = a_ext[WA] ? (~a_ext + 1'b1) : a_ext;
    mag_b    = b_ext[WB] ? (~b_ext + 1'b1) : b_ext;
    inb_zero = (bus.inb == '0);
  end

  // ---------------------------------------------------------- datapath
  // Remainder stays below |B|, so the shifted trial value needs one more bit
  // and the difference always fits back into the remainder width.
  always_comb begin
    trial = {rem_q, n_q[WN-1]};
    ge    = (trial >= {1'b0, b_q});
    diff  = trial[WB:0] - b_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      a_neg_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else if (accept) begin
      n_q     <= WN'(mag_a) << S;
      b_q     <= mag_b;
      rem_q   <= '0;
      r_q     <= '0;
      cnt_q   <= CNTW'(WN - 1);
      sign_q  <= bus.ina[WA-1] ^ bus.inb[WB-1];
      a_neg_q <= bus.ina[WA-1];
      dbz_q   <= inb_zero;
    end else if (state_q == DIV) begin
      n_q   <= n_q << 1;
      rem_q <= ge ? diff : trial[WB:0];
      r_q   <= {r_q[WN-2:0], ge};
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  // -------------------------------------------------- round / saturate
  // r_q carries WOF+1 fraction bits; its LSB is the guard bit.
  always_comb begin
    m       = (r_q >> 1) + {{(WN-1){1'b0}}, (ROUND & r_q[0])};
    m_ext   = CW'(m);
    mag_o   = m_ext[WO-1:0];
    neg_o   = ~mag_o + 1'b1;
    sat_pos = !sign_q && (m_ext > LIM_POS);
    sat_neg =  sign_q && (m_ext > LIM_NEG);
    res_out = sign_q ? neg_o : mag_o;
    res_ovf = 1'b0;
    if (dbz_q) begin
      res_out = a_neg_q ? OUT_MIN : OUT_MAX;
      res_ovf = 1'b1;
    end else if (sat_pos) begin
      res_out = OUT_MAX;
      res_ovf = 1'b1;
    end else if (sat_neg) begin
      res_out = OUT_MIN;
      res_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else if (state_q == FIN) begin
      out_q <= res_out;
      ovf_q <= res_ovf;
    end
  end

  // ------------------------------------------------------------ outputs
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out       = out_q;
  assign bus.overflow  = ovf_q;
`ifdef FXP_DIV_DBZ_EN
  assign bus.div_by_zero = dbz_q && (state_q == DONE);
`endif

endmodule

// File: tb/tb_fxp_div_seq.sv
// tb_fxp_div_seq
// Directed plus a few random divisions on the default Q8.8 configuration with
// ROUND=1, and a second ROUND=0 instance for the truncation case. Expected
// results are queued when operands are driven and compared when out_valid
// appears. Optional macro: FXP_DIV_DBZ_EN also checks div_by_zero.
module tb_fxp_div_seq;

  typedef struct {
    logic [15:0] o;
    logic        ov;
    logic        dz;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  exp_t sb[$];
  exp_t held;

  fxp_div_seq_if #(.WA(16), .WB(16), .WO(16)) bus  ();
  fxp_div_seq_if #(.WA(16), .WB(16), .WO(16)) bus0 ();

  fxp_div_seq #(.ROUND(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  fxp_div_seq #(.ROUND(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: R = floor(|A|*2^9/|B|), guard-bit rounding, Q8.8 saturation.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input bit rnd);
    exp_t   e;
    longint av, bv, r, m;
    bit     neg;
    av = longint'($signed(a));
    bv = longint'($signed(b));
    if (av < 0) av = -av;
    if (bv < 0) bv = -bv;
    if (b == 16'h0000) begin
      e.o = a[15] ? 16'h8000 : 16'h7FFF; e.ov = 1'b1; e.dz = 1'b1; e.lat = 2;
      return e;
    end
    e.dz = 1'b0; e.lat = 27;
    r   = (av << 9) / bv;
    m   = (r >> 1) + (rnd ? (r & 64'sd1) : 64'sd0);
    neg = a[15] ^ b[15];
    if (!neg && m > 32767)     begin e.o = 16'h7FFF; e.ov = 1'b1; end
    else if (neg && m > 32768) begin e.o = 16'h8000; e.ov = 1'b1; end
    else begin e.o = neg ? 16'(-m) : 16'(m); e.ov = 1'b0; end
    return e;
  endfunction

  task automatic push_exp(input logic [15:0] o, input logic ov, input logic dz, input int lat);
    exp_t e;
    e.o = o; e.ov = ov; e.dz = dz; e.lat = lat;
    sb.push_back(e);
  endtask

  // Drive an operand pair; returns #1 after the accepting edge.
  task automatic start(input logic [15:0] a, input logic [15:0] b);
    chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.ina = a; bus.inb = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.ina = 16'hDEAD; bus.inb = 16'hBEEF;
  endtask

  // Count edges from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_check(input string tag);
    exp_t e;
    int   lat;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    held = e;
    chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
    chk({tag, "_out"}, 32'(bus.out), 32'(e.o));
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'(e.ov));
`ifdef FXP_DIV_DBZ_EN
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(e.dz));
`endif
  endtask

  task automatic release_out(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          seen;
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.ina = '0; bus.inb = '0; bus.out_ready = 1'b0;
    bus0.in_valid = 1'b0; bus0.ina = '0; bus0.inb = '0; bus0.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
`ifdef FXP_DIV_DBZ_EN
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
`endif

    // 3.0 / 2.0
    push_exp(16'h0180, 1'b0, 1'b0, 27); start(16'h0300, 16'h0200);
    wait_check("d3by2"); release_out("d3by2");
    // 2.0 / 3.0 rounds up
    push_exp(16'h00AB, 1'b0, 1'b0, 27); start(16'h0200, 16'h0300);
    wait_check("d2by3"); release_out("d2by3");
    // -1.0 / 3.0
    push_exp(16'hFFAB, 1'b0, 1'b0, 27); start(16'hFF00, 16'h0300);
    wait_check("dm1by3"); release_out("dm1by3");
    // saturation both directions
    push_exp(16'h7FFF, 1'b1, 1'b0, 27); start(16'h6400, 16'h0040);
    wait_check("sat_pos"); release_out("sat_pos");
    push_exp(16'h8000, 1'b1, 1'b0, 27); start(16'h9C00, 16'h0040);
    wait_check("sat_neg"); release_out("sat_neg");
    // most negative / -1.0 exactly overflows the positive limit
    push_exp(16'h7FFF, 1'b1, 1'b0, 27); start(16'h8000, 16'hFF00);
    wait_check("minbym1"); release_out("minbym1");
    // divide by zero
    push_exp(16'h7FFF, 1'b1, 1'b1, 2); start(16'h0500, 16'h0000);
    wait_check("dbz_pos"); release_out("dbz_pos");
    push_exp(16'h8000, 1'b1, 1'b1, 2); start(16'hFB00, 16'h0000);
    wait_check("dbz_neg"); release_out("dbz_neg");

    // out_ready already high does not shorten latency
    bus.out_ready = 1'b1;
    push_exp(16'h0180, 1'b0, 1'b0, 27); start(16'h0300, 16'h0200);
    wait_check("rdy_early");
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("rdy_early_in_ready", 32'(bus.in_ready), 32'd1);

    // backpressure: result held, new operands ignored
    push_exp(16'h00AB, 1'b0, 1'b0, 27); start(16'h0200, 16'h0300);
    wait_check("bp");
    for (int i = 0; i < 10; i++) begin
      bus.ina = 16'h1234; bus.inb = 16'h0100; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_out", 32'(bus.out), 32'(held.o));
      chk("bp_overflow", 32'(bus.overflow), 32'(held.ov));
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    release_out("bp");
    push_exp(16'hFFAB, 1'b0, 1'b0, 27); start(16'hFF00, 16'h0300);
    wait_check("bp_b2b"); release_out("bp_b2b");

    // reset in DIV aborts the operation
    start(16'h0300, 16'h0200);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_out", 32'(bus.out), 32'd0);
    chk("abort_overflow", 32'(bus.overflow), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    push_exp(16'h0180, 1'b0, 1'b0, 27); start(16'h0300, 16'h0200);
    wait_check("post_abort"); release_out("post_abort");

    // random operands against the reference
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 2 == 1) rb = rb >> 6;
      if (i == 5) rb = 16'h0000;
      sb.push_back(model(ra, rb, 1'b1));
      start(ra, rb);
      wait_check("rand");
      release_out("rand");
    end

    // ROUND=0 instance truncates
    bus0.ina = 16'h0200; bus0.inb = 16'h0300; bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    seen = 1;
    while (!bus0.out_valid && seen < 100) begin
      @(posedge clk); #1;
      seen++;
    end
    chk("trunc_latency", 32'(seen), 32'd27);
    chk("trunc_out", 32'(bus0.out), 32'h00AA);
    chk("trunc_overflow", 32'(bus0.overflow), 32'd0);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
